// File: rtl/sid_pkg.sv
// sid_pkg: shared types and constants for the SID output mixer.
//   state_t      - mixer sequencer states (IDLE + nine sequence steps)
//   ADDR_ROUTE   - filter routing register address (bits [3:0] = {ext, v2, v1, v0})
//   ADDR_MODE    - mode/volume register address ({3OFF, HP, BP, LP, vol[3:0]})
//   DC_6581_DEF  - default 6581 DC offset added to the bypass sum
//   ACC_W_DEF    - default accumulator width
package sid_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        S_V0  = 4'd1,
        S_V1  = 4'd2,
        S_V2  = 4'd3,
        S_EXT = 4'd4,
        S_LP  = 4'd5,
        S_BP  = 4'd6,
        S_HP  = 4'd7,
        S_VOL = 4'd8,
        S_OUT = 4'd9
    } state_t;

    localparam logic [4:0] ADDR_ROUTE = 5'h17;
    localparam logic [4:0] ADDR_MODE  = 5'h18;

    localparam int          DC_6581_DEF = 1024;
    localparam int unsigned ACC_W_DEF   = 19;

endpackage

// File: rtl/sid_mixer_sat16.sv
// sat16: generic signed IN_W -> 16-bit saturating clamp (IN_W >= 16).
//   value   - signed input
//   clamped - value limited to [-32768, 32767]
module sat16 #(
    parameter int unsigned IN_W = 19
) (
    input  logic signed [IN_W-1:0] value,
    output logic signed [15:0]     clamped
);

    logic fits;

    // The value fits when every bit above bit 15 repeats the 16-bit sign bit.
    always_comb begin
        fits    = (value[IN_W-1:15] == {(IN_W-15){value[15]}});
        clamped = fits ? value[15:0] : (value[IN_W-1] ? 16'sh8000 : 16'sh7fff);
    end

endmodule

// File: rtl/sid_mixer.sv
// sid_mixer: time-multiplexed voice/filter routing, mixing and master volume.
//   clk, rst           - system clock, synchronous active-high reset
//   clkEn              - sample strobe, starts one mix sequence from IDLE
//   iVoice0..2, iExt   - signed voice and external sources
//   iLP, iBP, iHP      - signed filter outputs (previous sample)
//   iWE, iAddr, iData  - register write port (0x17 routing, 0x18 mode/volume)
//   i6581              - enables the 6581 DC offset
//   oFilt              - saturated filter-input sum, feeds the filter's iIn
//   oOut               - saturated, volume-scaled mix
//   oValid             - one-cycle pulse when oOut updates
module sid_mixer
    import sid_pkg::*;
#(
    parameter int          DC_6581 = DC_6581_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clkEn,
    input  logic signed [15:0] iVoice0,
    input  logic signed [15:0] iVoice1,
    input  logic signed [15:0] iVoice2,
    input  logic signed [15:0] iExt,
    input  logic signed [15:0] iLP,
    input  logic signed [15:0] iBP,
    input  logic signed [15:0] iHP,
    input  logic               iWE,
    input  logic [4:0]         iAddr,
    input  logic [7:0]         iData,
    input  logic               i6581,
    output logic signed [15:0] oFilt,
    output logic signed [15:0] oOut,
    output logic               oValid
);

    localparam int unsigned PROD_W = ACC_W + 5;
    localparam int unsigned SHR_W  = PROD_W - 4;

    state_t state, state_nxt;

    logic [3:0] route, mode, vol;
    logic [3:0] route_w, mode_w, vol_w;

    logic signed [ACC_W-1:0]  filt_acc, dir_acc, filt_nxt, dir_nxt, mix;
    logic signed [PROD_W-1:0] prod;
    logic signed [SHR_W-1:0]  shr;

    logic signed [15:0] src, filt_src, filt_clamped, filt_sat, out_sat;
    logic snap, acc_clr, to_filt, to_dir, load_filt, mul_en, load_out;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: one pass through the sequence per accepted clkEn
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clkEn) state_nxt = S_V0;
            S_V0:    state_nxt = S_V1;
            S_V1:    state_nxt = S_V2;
            S_V2:    state_nxt = S_EXT;
            S_EXT:   state_nxt = S_LP;
            S_LP:    state_nxt = S_BP;
            S_BP:    state_nxt = S_HP;
            S_HP:    state_nxt = S_VOL;
            S_VOL:   state_nxt = S_OUT;
            S_OUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Filter output for the current filter step, passed through the spare clamp
    always_comb begin
        case (state)
            S_BP:    filt_src = iBP;
            S_HP:    filt_src = iHP;
            default: filt_src = iLP;
        endcase
    end

    // Datapath controls and source select for the current step
    always_comb begin
        snap      = 1'b0;
        acc_clr   = 1'b0;
        to_filt   = 1'b0;
        to_dir    = 1'b0;
        load_filt = 1'b0;
        mul_en    = 1'b0;
        load_out  = 1'b0;
        src       = '0;
        case (state)
            IDLE:  snap = clkEn;
            S_V0: begin
                src     = iVoice0;
                acc_clr = 1'b1;
                to_filt = route_w[0];
                to_dir  = !route_w[0];
            end
            S_V1: begin
                src     = iVoice1;
                to_filt = route_w[1];
                to_dir  = !route_w[1];
            end
            S_V2: begin
                // 3OFF silences only the unrouted voice 2
                src     = iVoice2;
                to_filt = route_w[2];
                to_dir  = !route_w[2] && !mode_w[3];
            end
            S_EXT: begin
                src       = iExt;
                to_filt   = route_w[3];
                to_dir    = !route_w[3];
                load_filt = 1'b1;
            end
            S_LP: begin
                src    = filt_clamped;
                to_dir = mode_w[0];
            end
            S_BP: begin
                src    = filt_clamped;
                to_dir = mode_w[1];
            end
            S_HP: begin
                src    = filt_clamped;
                to_dir = mode_w[2];
            end
            S_VOL: mul_en   = 1'b1;
            S_OUT: load_out = 1'b1;
            default: ;
        endcase
    end

    // Accumulator update; oFilt loads from the post-ext value of filt_nxt
    always_comb begin
        filt_nxt = acc_clr ? '0 : filt_acc;
        dir_nxt  = acc_clr ? '0 : dir_acc;
        if (to_filt) filt_nxt = filt_nxt + ACC_W'(src);
        if (to_dir)  dir_nxt  = dir_nxt + ACC_W'(src);
    end

    assign mix = dir_acc + (i6581 ? ACC_W'(DC_6581) : ACC_W'(0));
    assign shr = SHR_W'(prod >>> 4);

    sat16 #(.IN_W(ACC_W)) u_sat_filt  (.value(filt_nxt), .clamped(filt_sat));
    sat16 #(.IN_W(SHR_W)) u_sat_out   (.value(shr),      .clamped(out_sat));
    sat16 #(.IN_W(16))    u_sat_spare (.value(filt_src), .clamped(filt_clamped));

    // Registers, snapshot, accumulators, multiplier and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            route    <= '0;
            mode     <= '0;
            vol      <= '0;
            route_w  <= '0;
            mode_w   <= '0;
            vol_w    <= '0;
            filt_acc <= '0;
            dir_acc  <= '0;
            prod     <= '0;
            oFilt    <= '0;
            oOut     <= '0;
            oValid   <= 1'b0;
        end else begin
            if (iWE && iAddr == ADDR_ROUTE) route <= iData[3:0];
            if (iWE && iAddr == ADDR_MODE) begin
                mode <= iData[7:4];
                vol  <= iData[3:0];
            end
            if (snap) begin
                route_w <= route;
                mode_w  <= mode;
                vol_w   <= vol;
            end
            filt_acc <= filt_nxt;
            dir_acc  <= dir_nxt;
            if (load_filt) oFilt <= filt_sat;
            if (mul_en)    prod  <= PROD_W'(mix) * PROD_W'($signed({1'b0, vol_w}));
            if (load_out)  oOut  <= out_sat;
            oValid <= load_out;
        end
    end

endmodule

// File: tb/tb_sid_mixer.sv
// tb_sid_mixer: directed self-checking bench for sid_mixer.
module tb_sid_mixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               clkEn;
    logic signed [15:0] iVoice0, iVoice1, iVoice2, iExt, iLP, iBP, iHP;
    logic               iWE;
    logic [4:0]         iAddr;
    logic [7:0]         iData;
    logic               i6581;
    logic signed [15:0] oFilt, oOut;
    logic               oValid;

    int checks   = 0;
    int failures = 0;

    sid_mixer dut (
        .clk(clk), .rst(rst), .clkEn(clkEn),
        .iVoice0(iVoice0), .iVoice1(iVoice1), .iVoice2(iVoice2), .iExt(iExt),
        .iLP(iLP), .iBP(iBP), .iHP(iHP),
        .iWE(iWE), .iAddr(iAddr), .iData(iData), .i6581(i6581),
        .oFilt(oFilt), .oOut(oOut), .oValid(oValid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
            $error("%s", tag);
        end
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        iWE = 1'b1; iAddr = a; iData = d;
        tick();
        iWE = 1'b0;
    endtask

    task automatic set_src(input int v0, input int v1, input int v2, input int ext,
                           input int lp, input int bp, input int hp);
        iVoice0 = 16'(v0); iVoice1 = 16'(v1); iVoice2 = 16'(v2); iExt = 16'(ext);
        iLP = 16'(lp); iBP = 16'(bp); iHP = 16'(hp);
    endtask

    // One full sequence: latency to oValid, both outputs, and single-cycle pulse
    task automatic run_sample(input string tag, input int exp_filt, input int exp_out,
                              input bit wr = 1'b0, input logic [4:0] wa = 5'h0,
                              input logic [7:0] wd = 8'h0);
        int n;
        clkEn = 1'b1;
        if (wr) begin iWE = 1'b1; iAddr = wa; iData = wd; end
        tick();
        clkEn = 1'b0;
        iWE   = 1'b0;
        n = 0;
        while (oValid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 9);
        check({tag, "_filt"}, 32'(oFilt), exp_filt);
        check({tag, "_out"}, 32'(oOut), exp_out);
        tick();
        check({tag, "_pulse"}, 32'(oValid), 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iData = '0; i6581 = 1'b0;
        set_src(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_filt", 32'(oFilt), 0);
        check("rst_out", 32'(oOut), 0);
        check("rst_valid", 32'(oValid), 0);
        rst = 1'b0;
        tick();

        // Routing: v0 to filter, v1+v2+LP bypass; BP/HP masked off
        wr_reg(5'h17, 8'h01);
        wr_reg(5'h18, 8'h1F);
        set_src(1000, 2000, 3000, 0, 400, 777, -555);
        run_sample("route", 1000, 5062);

        // 3OFF drops unrouted v2, but routed v2 still reaches the filter
        wr_reg(5'h17, 8'h00);
        wr_reg(5'h18, 8'h8F);
        set_src(0, 0, 8000, 0, 400, 777, -555);
        run_sample("off3", 0, 0);
        wr_reg(5'h17, 8'h04);
        run_sample("off3_rt", 8000, 0);
        wr_reg(5'h17, 8'h00);
        wr_reg(5'h18, 8'h0F);
        run_sample("v2_dir", 0, 7500);

        // BP and HP selected, LP not
        wr_reg(5'h18, 8'h6F);
        set_src(0, 0, 0, 0, 400, -1000, 3000);
        run_sample("bp_hp", 0, 1875);

        // Arithmetic shift of a negative product rounds toward -inf
        wr_reg(5'h18, 8'h01);
        set_src(-100, 0, 0, 0, 0, 0, 0);
        run_sample("neg_shr", 0, -7);

        // Saturation of both outputs
        wr_reg(5'h17, 8'h0F);
        wr_reg(5'h18, 8'h0F);
        set_src(32767, 32767, 32767, 32767, 0, 0, 0);
        run_sample("sat_filt", 32767, 0);
        wr_reg(5'h17, 8'h00);
        set_src(32767, 32767, 32767, 0, 0, 0, 0);
        run_sample("sat_pos", 0, 32767);
        set_src(-32768, -32768, -32768, 0, 0, 0, 0);
        run_sample("sat_neg", 0, -32768);

        // 6581 DC offset under three volumes
        i6581 = 1'b1;
        set_src(0, 0, 0, 0, 1111, 2222, 3333);
        wr_reg(5'h18, 8'h00);
        run_sample("dc_v0", 0, 0);
        wr_reg(5'h18, 8'h08);
        run_sample("dc_v8", 0, 512);
        wr_reg(5'h18, 8'h0F);
        run_sample("dc_v15", 0, 960);
        i6581 = 1'b0;

        // Write coinciding with the start edge is not seen by that sequence
        set_src(1600, 0, 0, 0, 0, 0, 0);
        run_sample("snap_old", 0, 1500, 1'b1, 5'h18, 8'h08);
        run_sample("snap_new", 0, 800);

        // Back-to-back strobes, an ignored extra strobe, a write during S_HP
        wr_reg(5'h18, 8'h0F);
        clkEn = 1'b1;
        tick();
        for (int k = 1; k <= 21; k++) begin
            clkEn = (k == 3 || k == 10);
            iWE   = (k == 7);
            iAddr = 5'h18;
            iData = 8'h08;
            tick();
            check($sformatf("tim_valid_%0d", k), 32'(oValid), (k == 9 || k == 19) ? 1 : 0);
            if (k == 9)  check("tim_out1", 32'(oOut), 1500);
            if (k == 19) check("tim_out2", 32'(oOut), 800);
        end
        clkEn = 1'b0;
        iWE   = 1'b0;

        // Reset mid-sequence aborts and clears everything
        wr_reg(5'h17, 8'h01);
        wr_reg(5'h18, 8'h1F);
        set_src(1000, 0, 0, 0, 400, 0, 0);
        run_sample("pre_rst", 1000, 375);
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        repeat (5) tick();
        check("mid_filt", 32'(oFilt), 1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_filt", 32'(oFilt), 0);
        check("mrst_out", 32'(oOut), 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (oValid === 1'b1) pulses++;
            tick();
        end
        check("mrst_pulses", 32'(pulses), 0);
        run_sample("post_rst", 0, 0);
        wr_reg(5'h17, 8'h01);
        wr_reg(5'h18, 8'h1F);
        run_sample("post_cfg", 1000, 375);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
